// File: rtl/msdap_mc_conv_engine.sv
// msdap_mc_conv_engine: time-multiplexed sparse-coefficient convolution over CHANNELS channels,
// one ACC_W-bit result per channel per start, streamed with its channel tag.
module msdap_mc_conv_engine #(
    parameter int CHANNELS     = 2,
    parameter int DATA_W       = 16,
    parameter int ACC_W        = 40,
    parameter int FRAC_SHIFT   = 16,
    parameter int NUM_SEG      = 16,
    parameter int COEFF_ADDR_W = 9,
    parameter int DATA_ADDR_W  = 8,
    localparam int CH_W        = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
    localparam int SEG_W       = NUM_SEG > 1 ? $clog2(NUM_SEG) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_ADDR_W-1:0]  newest_addr,
    output logic [CH_W-1:0]         ch_sel,
    output logic [SEG_W-1:0]        rj_addr,
    input  logic [15:0]             rj_data,
    output logic [COEFF_ADDR_W-1:0] coeff_addr,
    input  logic [15:0]             coeff_data,
    output logic [DATA_ADDR_W-1:0]  data_addr,
    input  logic [DATA_W-1:0]       data_data,
    output logic                    busy,
    output logic                    result_valid,
    output logic [CH_W-1:0]         result_ch,
    output logic [ACC_W-1:0]        result,
    output logic                    overrun
);
    typedef enum logic [2:0] {IDLE, RJ_RD, RJ_LAT, CF_RD, CF_LAT, DT_LAT, SHIFT, OUT} state_t;
    state_t state, state_n;
    logic [SEG_W-1:0] seg;
    logic [COEFF_ADDR_W-1:0] cptr;
    logic [COEFF_ADDR_W:0] cnt;
    logic [DATA_ADDR_W-1:0] newest, dly;
    logic neg;
    logic signed [ACC_W-1:0] acc, term;
    logic last_seg, last_ch;
    logic unused_bits;
    assign unused_bits = ^{rj_data[15:COEFF_ADDR_W+1], coeff_data[15:9]};
    assign term = ACC_W'(signed'(data_data)) <<< FRAC_SHIFT;
    assign last_seg = seg == SEG_W'(NUM_SEG - 1);
    assign last_ch = ch_sel == CH_W'(CHANNELS - 1);
    assign busy = state != IDLE;
    assign result_valid = state == OUT;
    assign rj_addr = seg;
    assign coeff_addr = cptr;
    // delay is taken straight from the bus in CF_LAT so the data read overlaps DT_LAT
    assign data_addr = newest - (state == CF_LAT ? DATA_ADDR_W'(coeff_data[7:0]) : dly);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? RJ_RD : IDLE;
            RJ_RD:   state_n = RJ_LAT;
            RJ_LAT:  state_n = rj_data[COEFF_ADDR_W:0] == '0 ? SHIFT : CF_RD;
            CF_RD:   state_n = CF_LAT;
            CF_LAT:  state_n = DT_LAT;
            DT_LAT:  state_n = cnt == (COEFF_ADDR_W+1)'(1) ? SHIFT : CF_RD;
            SHIFT:   state_n = last_seg ? OUT : RJ_RD;
            OUT:     state_n = last_ch ? IDLE : RJ_RD;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ch_sel    <= '0;
            seg       <= '0;
            cptr      <= '0;
            cnt       <= '0;
            acc       <= '0;
            newest    <= '0;
            dly       <= '0;
            neg       <= 1'b0;
            result    <= '0;
            result_ch <= '0;
            overrun   <= 1'b0;
        end else begin
            state   <= state_n;
            overrun <= start && state != IDLE;
            case (state)
                IDLE: if (start) begin
                    newest <= newest_addr;
                    ch_sel <= '0;
                    seg    <= '0;
                    cptr   <= '0;
                    acc    <= '0;
                end
                RJ_LAT: cnt <= rj_data[COEFF_ADDR_W:0];
                CF_RD:  cptr <= cptr + 1'b1;
                CF_LAT: begin
                    dly <= DATA_ADDR_W'(coeff_data[7:0]);
                    neg <= coeff_data[8];
                end
                DT_LAT: begin
                    acc <= neg ? acc - term : acc + term;
                    cnt <= cnt - 1'b1;
                end
                SHIFT: begin
                    acc <= acc >>> 1;
                    seg <= last_seg ? '0 : seg + 1'b1;
                    if (last_seg) begin
                        result    <= acc >>> 1;
                        result_ch <= ch_sel;
                    end
                end
                OUT: if (!last_ch) begin
                    ch_sel <= ch_sel + 1'b1;
                    seg    <= '0;
                    cptr   <= '0;
                    acc    <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_msdap_mc_conv_engine.sv
// tb_msdap_mc_conv_engine: directed and randomized runs against a loop-level model with
// per-channel memories emulated at 1-cycle synchronous read latency.
module tb_msdap_mc_conv_engine;
    localparam int CH = 2;
    logic clk = 0, rst = 1, start = 0;
    logic [7:0] newest_addr = 0;
    logic [0:0] ch_sel, result_ch;
    logic [3:0] rj_addr;
    logic [15:0] rj_data, coeff_data, data_data;
    logic [8:0] coeff_addr;
    logic [7:0] data_addr;
    logic busy, result_valid, overrun;
    logic [39:0] result;
    int checks = 0, errors = 0;
    logic [15:0] rj_mem [CH][16];
    logic [15:0] cf_mem [CH][512];
    logic [15:0] dt_mem [CH][256];
    logic [39:0] exp_res [CH];
    int exp_cyc [CH];

    msdap_mc_conv_engine dut (
        .clk(clk), .rst(rst), .start(start), .newest_addr(newest_addr), .ch_sel(ch_sel),
        .rj_addr(rj_addr), .rj_data(rj_data), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .data_addr(data_addr), .data_data(data_data), .busy(busy), .result_valid(result_valid),
        .result_ch(result_ch), .result(result), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rj_data    <= rj_mem[ch_sel][rj_addr];
        coeff_data <= cf_mem[ch_sel][coeff_addr];
        data_data  <= dt_mem[ch_sel][data_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < 16; i++) rj_mem[c][i] = 0;
            for (int i = 0; i < 512; i++) cf_mem[c][i] = 0;
            for (int i = 0; i < 256; i++) dt_mem[c][i] = 0;
        end
    endtask

    task automatic rand_mem();
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < 16; i++) rj_mem[c][i] = (16'($urandom) & 16'hFC00) | 16'($urandom_range(0, 3));
            for (int i = 0; i < 512; i++) cf_mem[c][i] = 16'($urandom);
            for (int i = 0; i < 256; i++) dt_mem[c][i] = 16'($urandom);
        end
    endtask

    // Sum of signed, delayed, 2^16-scaled samples per segment, halved after every segment.
    task automatic model(input logic [7:0] na);
        int t, p, n, r;
        logic signed [39:0] acc, term;
        logic [15:0] cf, x;
        logic [7:0] a;
        t = 0;
        for (int c = 0; c < CH; c++) begin
            acc = 0;
            p = 0;
            n = 0;
            for (int s = 0; s < 16; s++) begin
                r = int'(rj_mem[c][s][9:0]);
                for (int j = 0; j < r; j++) begin
                    cf = cf_mem[c][p];
                    a = na - cf[7:0];
                    x = dt_mem[c][a];
                    term = 40'(signed'(x)) * 65536;
                    acc = cf[8] ? acc - term : acc + term;
                    p = (p + 1) % 512;
                    n++;
                end
                acc = acc >>> 1;
            end
            exp_res[c] = acc;
            t += 49 + 3 * n;
            exp_cyc[c] = t;
        end
    endtask

    // ovr: cycle (after start) in which a stray start is driven; -1 none, -2 final OUT cycle.
    task automatic run(input logic [7:0] na, input int ovr);
        int t, got, o;
        model(na);
        o = ovr == -2 ? exp_cyc[CH-1] : ovr;
        start = 1;
        newest_addr = na;
        t = 0;
        got = 0;
        while (got < CH && t < 20000) begin
            @(negedge clk);
            t++;
            check("overrun", overrun, t == o + 1);
            if (t == 1) check("busy_start", busy, 1);
            if (result_valid) begin
                check("result", result, exp_res[got]);
                check("result_ch", result_ch, got);
                check("result_cycle", t, exp_cyc[got]);
                got++;
            end
            start = t == o;
            newest_addr = 8'($urandom);
        end
        check("result_count", got, CH);
        @(negedge clk);
        t++;
        start = 0;
        check("overrun_end", overrun, t == o + 1);
        check("busy_end", busy, 0);
        check("valid_end", result_valid, 0);
    endtask

    initial begin
        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_result", result, 0);
        check("rst_ch", ch_sel, 0);
        check("rst_addr", {rj_addr, coeff_addr, data_addr}, 0);
        rst = 0;
        run(8'h00, -1);
        rj_mem[0][0] = 16'h0001;
        dt_mem[0][8'h10] = 16'h4000;
        rj_mem[1][15] = 16'h0001;
        dt_mem[1][8'h10] = 16'h0002;
        run(8'h10, -1);
        cf_mem[0][0] = 16'h0100;
        run(8'h10, -1);
        cf_mem[0][0] = 16'h0005;
        dt_mem[0][8'hFE] = 16'h1234;
        dt_mem[0][8'h03] = 16'h7777;
        run(8'h03, -1);
        run(8'h03, 20);
        run(8'h03, -2);
        start = 1;
        newest_addr = 8'h03;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", result_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_ch", {ch_sel, result_ch}, 0);
        check("mid_rst_addr", {rj_addr, coeff_addr, data_addr}, 0);
        run(8'h03, -1);
        for (int i = 0; i < 6; i++) begin
            rand_mem();
            run(8'($urandom), i % 3 == 0 ? -1 : (i % 3 == 1 ? int'($urandom_range(2, 80)) : -2));
        end
        rand_mem();
        rj_mem[0][0] = 16'd600;
        run(8'($urandom), -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/msdap_mc_conv_engine.md
Name: msdap_mc_conv_engine

Overview:
- Parametrised successor to the single-channel MSDAP ALU.
- Time-multiplexes sparse-coefficient (Rj-segmented) convolution across CHANNELS audio channels.
- Each channel has its own Rj, coefficient and data memories. These sit outside the block, are muxed by ch_sel, and all have 1-cycle synchronous read latency.
- Triggered once per input sample by the control FSM; each channel's ACC_W-bit result is streamed, tagged with its channel, to the P2S stage.

Parameters:
- CHANNELS, 2: number of channels processed per start (≥1).
- DATA_W, 16: input sample width.
- ACC_W, 40: accumulator/result width.
- FRAC_SHIFT, 16: left alignment of sample inside accumulator.
- NUM_SEG, 16: number of Rj segments.
- COEFF_ADDR_W, 9: coefficient memory address width.
- DATA_ADDR_W, 8: data circular buffer address width.

Ports:
- clk  in  1  system clock (SCLK domain)
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: new sample written, begin conversion
- newest_addr  in  DATA_ADDR_W  address of newest sample, sampled on accepted start
- ch_sel  out  clog2(CHANNELS) (min 1)  channel currently addressed; muxes memories
- rj_addr  out  clog2(NUM_SEG)  Rj memory read address
- rj_data  in  16  Rj count read data (low COEFF_ADDR_W+1 bits used)
- coeff_addr  out  COEFF_ADDR_W  coefficient memory read address
- coeff_data  in  16  coefficient: bit8 sign (1 = subtract), bits7:0 delay k
- data_addr  out  DATA_ADDR_W  data memory read address
- data_data  in  DATA_W  sample read data
- busy  out  1  high from accepted start until last result issued
- result_valid  out  1  one-cycle pulse, result/result_ch valid
- result_ch  out  clog2(CHANNELS)  channel of result
- result  out  ACC_W  convolution output
- overrun  out  1  one-cycle pulse when start arrives while busy

Behaviour:
- Single clock clk. Reset synchronous active-high on rst.
- Reset (any state, including mid-conversion):
  - FSM → IDLE.
  - busy, result_valid, overrun = 0.
  - result = 0, result_ch = 0, ch_sel = 0.
  - All addresses = 0, accumulator = 0.
  - Partial results are discarded.
- Read latency: any address driven in cycle t has its data valid and captured at the clock edge ending cycle t+1.
- FSM states: IDLE, RJ_RD, RJ_LAT, CF_RD, CF_LAT, DT_LAT, SHIFT, OUT.
  - IDLE: on start, latch newest_addr; ch_sel = 0, seg = 0, cptr = 0, acc = 0; → RJ_RD.
  - RJ_RD: rj_addr = seg → RJ_LAT.
  - RJ_LAT: cnt = rj_data. If cnt == 0 → SHIFT, else → CF_RD.
  - CF_RD: coeff_addr = cptr; cptr increments mod 2^COEFF_ADDR_W → CF_LAT.
  - CF_LAT: latch coeff_data; data_addr = latched_newest − k, mod 2^DATA_ADDR_W (wrap-around required) → DT_LAT.
  - DT_LAT: term = sign-extend(data_data) << FRAC_SHIFT, ACC_W wide.
    - acc = acc ± term, modulo 2^ACC_W, no saturation.
    - cnt decrements; if cnt ≠ 0 → CF_RD, else → SHIFT.
  - SHIFT: acc = acc >>> 1 (arithmetic); seg increments. If seg was NUM_SEG−1 → OUT, else → RJ_RD.
  - OUT: result = acc, result_ch = ch_sel, result_valid = 1 for this cycle.
    - If ch_sel == CHANNELS−1 → IDLE, busy drops the next cycle.
    - Otherwise ch_sel increments; seg, cptr, acc cleared → RJ_RD.
- Latency per channel: 3·NUM_SEG + 3·Σrj cycles after entering RJ_RD. result_valid asserts in the following cycle.
- Start while busy: ignored (no restart, newest_addr not relatched); overrun pulses the next cycle.
- Start in the same cycle as the final OUT: ignored, overrun pulses.
- Start one cycle after OUT (IDLE): accepted.
- Σrj exceeding coefficient depth: cptr wraps silently. Negative delays are resolved by the data memory (pre-cleared to zero by control).
- result and result_ch hold their values until the next OUT.

Test Plan:
1. All rj = 0, start, CHANNELS = 2 → result_valid at cycles 49 and 98 after start, both result = 0; busy low at cycle 99.
2. Ch0: rj[0] = 1, coeff 0x0000, data[newest] = 0x4000 → result = 0x00_0000_4000 (16 shifts), result_ch = 0, 51 cycles after RJ_RD entry.
3. Same as 2 with coeff 0x0100 → result = 0xFF_FFFF_C000. Ch1 with rj[15] = 1, coeff 0x0000, x = 0x0002 → 0x00_0000_0000 + (0x2<<16)>>1 = 0x00_0001_0000.
4. newest_addr = 0x03, coeff k = 0x05 → data_addr = 0xFE observed in DT_LAT fetch; wrap verified.
5. Start pulse during busy → overrun one-cycle pulse, results identical to a run without the pulse.
6. rst asserted mid-DT_LAT → next cycle busy = 0, result_valid = 0, addresses = 0. A new start then yields a correct full result.
